// File: rtl/rv32imf_sim_mem.sv
// Dual-port req/gnt/rvalid memory model for the rv32imf bench (1-cycle read latency).
// Optional grant backpressure from an 8-bit LFSR when SIM_MEM_STALL_EN is defined.
module rv32imf_sim_mem #(
  parameter int unsigned DEPTH     = 65536,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_be_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [0:DEPTH-1];

  logic [AW-1:0] instr_idx;
  logic [AW-1:0] data_idx;
  logic          instr_acc;
  logic          data_acc;

  logic          instr_rvalid_q, instr_rvalid_d;
  logic [31:0]   instr_rdata_q,  instr_rdata_d;
  logic          data_rvalid_q,  data_rvalid_d;
  logic [31:0]   data_rdata_q,   data_rdata_d;

  // Out-of-range addresses wrap modulo DEPTH; byte offset bits are dropped.
  function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] word;
    word = (addr - BASE_ADDR) >> 2;
    return AW'(word % DEPTH);
  endfunction

  assign instr_idx = word_idx(instr_addr_i);
  assign data_idx  = word_idx(data_addr_i);

`ifdef SIM_MEM_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign instr_gnt_o = instr_req_i & lfsr_q[0];
  assign data_gnt_o  = data_req_i & lfsr_q[1];
`else
  assign instr_gnt_o = instr_req_i;
  assign data_gnt_o  = data_req_i;
`endif

  assign instr_acc = instr_req_i & instr_gnt_o;
  assign data_acc  = data_req_i & data_gnt_o;

  // Reads sample the array before this edge's write lands (read-before-write).
  always_comb begin
    instr_rvalid_d = instr_acc;
    instr_rdata_d  = instr_rdata_q;
    data_rvalid_d  = data_acc;
    data_rdata_d   = data_rdata_q;
    if (instr_acc) begin
      instr_rdata_d = mem[instr_idx];
    end
    if (data_acc) begin
      data_rdata_d = mem[data_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_rvalid_q <= 1'b0;
      instr_rdata_q  <= 32'h0;
      data_rvalid_q  <= 1'b0;
      data_rdata_q   <= 32'h0;
    end else begin
      instr_rvalid_q <= instr_rvalid_d;
      instr_rdata_q  <= instr_rdata_d;
      data_rvalid_q  <= data_rvalid_d;
      data_rdata_q   <= data_rdata_d;
    end
  end

  // Writes are not gated by reset so a write at the reset edge still lands.
  always_ff @(posedge clk_i) begin
    if (data_acc && data_we_i) begin
      for (int n = 0; n < 4; n++) begin
        if (data_be_i[n]) begin
          mem[data_idx][8*n +: 8] <= data_wdata_i[8*n +: 8];
        end
      end
    end
  end

  assign instr_rvalid_o = instr_rvalid_q;
  assign instr_rdata_o  = instr_rdata_q;
  assign data_rvalid_o  = data_rvalid_q;
  assign data_rdata_o   = data_rdata_q;

endmodule

// File: tb/tb_rv32imf_sim_mem.sv
// Scoreboard bench for rv32imf_sim_mem: expected words queued at issue,
// popped when the matching rvalid appears.
module tb_rv32imf_sim_mem;

  localparam int unsigned DEPTH = 65536;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_be_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;

  always #5 clk = ~clk;

  rv32imf_sim_mem #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .instr_req_i   (instr_req_i),
    .instr_addr_i  (instr_addr_i),
    .instr_gnt_o   (instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o (instr_rdata_o),
    .data_req_i    (data_req_i),
    .data_addr_i   (data_addr_i),
    .data_we_i     (data_we_i),
    .data_wdata_i  (data_wdata_i),
    .data_be_i     (data_be_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o)
  );

  typedef struct packed {
    logic        ir;
    logic [31:0] ia;
    logic [31:0] ie;
    logic        dr;
    logic [31:0] da;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] de;
    logic        dc;
  } stim_t;

  typedef struct packed {
    logic        care;
    logic [31:0] d;
  } exp_t;

  int   checks = 0;
  int   fails  = 0;
  exp_t iq[$];
  exp_t dq[$];

  function automatic stim_t mk(
    input logic ir, input logic [31:0] ia, input logic [31:0] ie,
    input logic dr, input logic [31:0] da, input logic we,
    input logic [31:0] wd, input logic [3:0] be,
    input logic [31:0] de, input logic dc);
    return '{ir, ia, ie, dr, da, we, wd, be, de, dc};
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic apply(input stim_t s);
    instr_req_i  = s.ir;
    instr_addr_i = s.ia;
    data_req_i   = s.dr;
    data_addr_i  = s.da;
    data_we_i    = s.we;
    data_wdata_i = s.wd;
    data_be_i    = s.be;
  endtask

  task automatic idle();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic test_reset();
    logic exp_dg;
    exp_dg = 1'b1;
`ifdef SIM_MEM_STALL_EN
    exp_dg = 1'b0;
`endif
    rst_i = 1'b1;
    apply(mk(1, 32'h0, 0, 1, 32'h0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_rvalid got %b%b want 00", instr_rvalid_o, data_rvalid_o);
    end
    checks++;
    if (instr_rdata_o !== 32'h0 || data_rdata_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_rdata got %h %h want 0 0", instr_rdata_o, data_rdata_o);
    end
    checks++;
    if (instr_gnt_o !== 1'b1 || data_gnt_o !== exp_dg) begin
      fails++;
      $display("FAIL reset_gnt got %b%b want 1%b", instr_gnt_o, data_gnt_o, exp_dg);
    end
    @(negedge clk);
    rst_i = 1'b0;
    idle();
    @(posedge clk);
  endtask

  task automatic test_fetch();
    stim_t s[$];
    exp_t  e;
    iq.delete();
    dq.delete();
    s.push_back(mk(0, 0, 0, 1, 32'h000, 1, 32'h0000_0013, 4'hF, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 32'h004, 1, 32'h0010_0093, 4'hF, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 32'h008, 1, 32'hCAFE_0002, 4'hF, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 32'h100, 1, 32'h5555_AAAA, 4'hF, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 32'h200, 1, 32'h1111_1111, 4'hF, 0, 0));
    s.push_back(mk(1, 32'h0, 32'h0000_0013, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 32'h4, 32'h0010_0093, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[k]) begin
      @(negedge clk);
      apply(s[k]);
      #1;
      checks++;
      if (instr_gnt_o !== s[k].ir || data_gnt_o !== s[k].dr) begin
        fails++;
        $display("FAIL fetch_gnt[%0d] got %b%b want %b%b", k, instr_gnt_o, data_gnt_o, s[k].ir, s[k].dr);
      end
      if (s[k].ir) iq.push_back('{1'b1, s[k].ie});
      if (s[k].dr) dq.push_back('{s[k].dc, s[k].de});
      @(posedge clk);
      #1;
      checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== {iq.size() != 0, dq.size() != 0}) begin
        fails++;
        $display("FAIL fetch_rvalid[%0d] got %b%b want %b%b", k, instr_rvalid_o, data_rvalid_o, iq.size() != 0, dq.size() != 0);
        iq.delete();
        dq.delete();
      end else begin
        if (instr_rvalid_o) begin
          e = iq.pop_front();
          checks++;
          if (instr_rdata_o !== e.d) begin
            fails++;
            $display("FAIL fetch_irdata[%0d] got %h want %h", k, instr_rdata_o, e.d);
          end
        end
        if (data_rvalid_o) begin
          e = dq.pop_front();
          if (e.care) begin
            checks++;
            if (data_rdata_o !== e.d) begin
              fails++;
              $display("FAIL fetch_drdata[%0d] got %h want %h", k, data_rdata_o, e.d);
            end
          end
        end
      end
    end
  endtask

  task automatic test_write_read();
    stim_t s[$];
    exp_t  e;
    iq.delete();
    dq.delete();
    s.push_back(mk(0, 0, 0, 1, 32'h100, 1, 32'hDEAD_BEEF, 4'hF, 32'h5555_AAAA, 1));
    s.push_back(mk(0, 0, 0, 1, 32'h100, 0, 0, 0, 32'hDEAD_BEEF, 1));
    s.push_back(mk(0, 0, 0, 1, 32'h100, 1, 32'h0000_0041, 4'b0001, 32'hDEAD_BEEF, 1));
    s.push_back(mk(0, 0, 0, 1, 32'h100, 0, 0, 0, 32'hDEAD_BE41, 1));
    s.push_back(mk(0, 0, 0, 1, 32'h100, 1, 32'h1234_0000, 4'b1100, 32'hDEAD_BE41, 1));
    s.push_back(mk(0, 0, 0, 1, 32'h100, 0, 0, 0, 32'h1234_BE41, 1));
    s.push_back(mk(0, 0, 0, 1, 32'h100, 1, 32'hFFFF_FFFF, 4'b0000, 32'h1234_BE41, 1));
    s.push_back(mk(0, 0, 0, 1, 32'h102, 0, 0, 0, 32'h1234_BE41, 1));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[k]) begin
      @(negedge clk);
      apply(s[k]);
      #1;
      checks++;
      if (instr_gnt_o !== s[k].ir || data_gnt_o !== s[k].dr) begin
        fails++;
        $display("FAIL wr_gnt[%0d] got %b%b want %b%b", k, instr_gnt_o, data_gnt_o, s[k].ir, s[k].dr);
      end
      if (s[k].dr) dq.push_back('{s[k].dc, s[k].de});
      @(posedge clk);
      #1;
      checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== {1'b0, dq.size() != 0}) begin
        fails++;
        $display("FAIL wr_rvalid[%0d] got %b%b want 0%b", k, instr_rvalid_o, data_rvalid_o, dq.size() != 0);
        dq.delete();
      end else if (data_rvalid_o) begin
        e = dq.pop_front();
        checks++;
        if (data_rdata_o !== e.d) begin
          fails++;
          $display("FAIL wr_drdata[%0d] got %h want %h", k, data_rdata_o, e.d);
        end
      end
    end
  endtask

  task automatic test_collision();
    stim_t s[$];
    exp_t  e;
    iq.delete();
    dq.delete();
    s.push_back(mk(1, 32'h200, 32'h1111_1111, 1, 32'h200, 1, 32'h2222_2222, 4'hF, 32'h1111_1111, 1));
    s.push_back(mk(1, 32'h200, 32'h2222_2222, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[k]) begin
      @(negedge clk);
      apply(s[k]);
      if (s[k].ir) iq.push_back('{1'b1, s[k].ie});
      if (s[k].dr) dq.push_back('{s[k].dc, s[k].de});
      @(posedge clk);
      #1;
      checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== {iq.size() != 0, dq.size() != 0}) begin
        fails++;
        $display("FAIL coll_rvalid[%0d] got %b%b want %b%b", k, instr_rvalid_o, data_rvalid_o, iq.size() != 0, dq.size() != 0);
        iq.delete();
        dq.delete();
      end else begin
        if (instr_rvalid_o) begin
          e = iq.pop_front();
          checks++;
          if (instr_rdata_o !== e.d) begin
            fails++;
            $display("FAIL coll_irdata[%0d] got %h want %h", k, instr_rdata_o, e.d);
          end
        end
        if (data_rvalid_o) begin
          e = dq.pop_front();
          checks++;
          if (data_rdata_o !== e.d) begin
            fails++;
            $display("FAIL coll_drdata[%0d] got %h want %h", k, data_rdata_o, e.d);
          end
        end
      end
    end
  endtask

  task automatic test_wrap();
    stim_t s[$];
    exp_t  e;
    logic [31:0] wa;
    wa = DEPTH * 4 + 8;
    iq.delete();
    dq.delete();
    s.push_back(mk(1, wa, 32'hCAFE_0002, 1, wa, 0, 0, 0, 32'hCAFE_0002, 1));
    s.push_back(mk(1, 32'h0B, 32'hCAFE_0002, 1, wa + 32'h4, 0, 0, 0, 32'h0000_0013, 0));
    s.push_back(mk(0, 0, 0, 1, wa - 32'h4, 0, 0, 0, 32'h0010_0093, 1));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[k]) begin
      @(negedge clk);
      apply(s[k]);
      if (s[k].ir) iq.push_back('{1'b1, s[k].ie});
      if (s[k].dr) dq.push_back('{s[k].dc, s[k].de});
      @(posedge clk);
      #1;
      checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== {iq.size() != 0, dq.size() != 0}) begin
        fails++;
        $display("FAIL wrap_rvalid[%0d] got %b%b want %b%b", k, instr_rvalid_o, data_rvalid_o, iq.size() != 0, dq.size() != 0);
        iq.delete();
        dq.delete();
      end else begin
        if (instr_rvalid_o) begin
          e = iq.pop_front();
          checks++;
          if (instr_rdata_o !== e.d) begin
            fails++;
            $display("FAIL wrap_irdata[%0d] got %h want %h", k, instr_rdata_o, e.d);
          end
        end
        if (data_rvalid_o) begin
          e = dq.pop_front();
          if (e.care) begin
            checks++;
            if (data_rdata_o !== e.d) begin
              fails++;
              $display("FAIL wrap_drdata[%0d] got %h want %h", k, data_rdata_o, e.d);
            end
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    exp_t  e;
    iq.delete();
    dq.delete();
    s.push_back(mk(1, 32'h0, 32'h0000_0013, 1, 32'h8, 0, 0, 0, 32'hCAFE_0002, 1));
    s.push_back(mk(1, 32'h4, 32'h0010_0093, 1, 32'h4, 0, 0, 0, 32'h0010_0093, 1));
    s.push_back(mk(1, 32'h8, 32'hCAFE_0002, 1, 32'h0, 0, 0, 0, 32'h0000_0013, 1));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[k]) begin
      @(negedge clk);
      apply(s[k]);
      if (s[k].ir) iq.push_back('{1'b1, s[k].ie});
      if (s[k].dr) dq.push_back('{s[k].dc, s[k].de});
      @(posedge clk);
      #1;
      checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== {iq.size() != 0, dq.size() != 0}) begin
        fails++;
        $display("FAIL b2b_rvalid[%0d] got %b%b want %b%b", k, instr_rvalid_o, data_rvalid_o, iq.size() != 0, dq.size() != 0);
        iq.delete();
        dq.delete();
      end else begin
        if (instr_rvalid_o) begin
          e = iq.pop_front();
          checks++;
          if (instr_rdata_o !== e.d) begin
            fails++;
            $display("FAIL b2b_irdata[%0d] got %h want %h", k, instr_rdata_o, e.d);
          end
        end
        if (data_rvalid_o) begin
          e = dq.pop_front();
          checks++;
          if (data_rdata_o !== e.d) begin
            fails++;
            $display("FAIL b2b_drdata[%0d] got %h want %h", k, data_rdata_o, e.d);
          end
        end
      end
    end
    checks++;
    if (instr_rdata_o !== 32'hCAFE_0002 || data_rdata_o !== 32'h0000_0013) begin
      fails++;
      $display("FAIL b2b_hold got %h %h want cafe0002 00000013", instr_rdata_o, data_rdata_o);
    end
  endtask

  task automatic test_reset_pending();
    @(negedge clk);
    apply(mk(1, 32'h4, 0, 1, 32'h100, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    checks++;
    if (instr_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b1 ||
        instr_rdata_o !== 32'h0010_0093 || data_rdata_o !== 32'h1234_BE41) begin
      fails++;
      $display("FAIL rstp_pre got %b%b %h %h want 11 00100093 1234be41", instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o);
    end
    @(negedge clk);
    rst_i = 1'b1;
    apply(mk(1, 32'h0, 0, 1, 32'h300, 1, 32'h7777_7777, 4'hF, 0, 0));
    @(posedge clk);
    #1;
    checks++;
    if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0) begin
      fails++;
      $display("FAIL rstp_rvalid got %b%b want 00", instr_rvalid_o, data_rvalid_o);
    end
    checks++;
    if (instr_rdata_o !== 32'h0 || data_rdata_o !== 32'h0) begin
      fails++;
      $display("FAIL rstp_rdata got %h %h want 0 0", instr_rdata_o, data_rdata_o);
    end
    @(negedge clk);
    rst_i = 1'b0;
    apply(mk(0, 0, 0, 1, 32'h300, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    checks++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h7777_7777) begin
      fails++;
      $display("FAIL rstp_commit got %b %h want 1 77777777", data_rvalid_o, data_rdata_o);
    end
    @(negedge clk);
    idle();
  endtask

`ifdef SIM_MEM_STALL_EN
  task automatic test_stall();
    logic [7:0] lm;
    int         ni;
    int         nd;
    @(negedge clk);
    rst_i = 1'b1;
    apply(mk(1, 32'h0, 0, 1, 32'h0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    lm = 8'hA5;
    ni = 0;
    nd = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++;
      if (instr_gnt_o !== lm[0] || data_gnt_o !== lm[1]) begin
        fails++;
        $display("FAIL stall_gnt[%0d] got %b%b want %b%b", k, instr_gnt_o, data_gnt_o, lm[0], lm[1]);
      end
      if (lm[0]) ni++;
      if (lm[1]) nd++;
      @(posedge clk);
      #1;
      checks++;
      if (instr_rvalid_o !== (ni != 0) || data_rvalid_o !== (nd != 0)) begin
        fails++;
        $display("FAIL stall_rvalid[%0d] got %b%b want %b%b", k, instr_rvalid_o, data_rvalid_o, ni != 0, nd != 0);
      end
      ni = 0;
      nd = 0;
      lm = lfsr_step(lm);
      @(negedge clk);
    end
    idle();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    idle();
    test_reset();
`ifdef SIM_MEM_STALL_EN
    test_stall();
`else
    test_fetch();
    test_write_read();
    test_collision();
    test_wrap();
    test_back_to_back();
    test_reset_pending();
`endif
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/rv32imf_sim_mem.md
# rv32imf_sim_mem

Simulation-only dual-port memory model serving the rv32imf core's instruction fetch port and load/store data port. It uses a req/gnt/rvalid handshake: requests are accepted in the grant cycle and answered one cycle later. The storage array is preloaded by the bench with `$readmemh` and is also reachable hierarchically. The block sits beside the core in the top-level bench. The bench snoops the data bus itself for stdout and tohost writes.

## Interface
- `DEPTH`, default 65536: number of 32-bit words in the array `mem`.
- `BASE_ADDR`, default 32'h0000_0000: byte address that maps to `mem[0]`.
- `clk_i` input 1: clock; all state changes on its rising edge.
- `rst_i` input 1: reset; synchronous, active-high.
- `instr_req_i` input 1: fetch request.
- `instr_addr_i` input 32: fetch byte address.
- `instr_gnt_o` output 1: fetch request accepted this cycle.
- `instr_rvalid_o` output 1: fetch response valid.
- `instr_rdata_o` output 32: fetched word.
- `data_req_i` input 1: data request.
- `data_addr_i` input 32: data byte address.
- `data_we_i` input 1: 1 means write, 0 means read.
- `data_wdata_i` input 32: write data, lane-aligned.
- `data_be_i` input 4: byte enables; bit n selects byte lane n (bits 8n+7:8n).
- `data_gnt_o` output 1: data request accepted this cycle.
- `data_rvalid_o` output 1: data response valid.
- `data_rdata_o` output 32: read word.

## Operation
- Array `mem[0:DEPTH-1]` holds 32-bit words, little-endian by lane.
- Word index = ((addr − BASE_ADDR) >> 2) mod DEPTH. Out-of-range addresses wrap; there is no error response.
- Address bits [1:0] are ignored. The core presents lane-aligned data and byte enables.
- A request is accepted when req and gnt are both 1 at a rising edge.
- gnt is combinational: gnt = req (except under Configuration).
- Instruction port: an accepted fetch returns `mem[idx]` on `instr_rdata_o` with `instr_rvalid_o`=1 in the next cycle.
- Data read: same as a fetch, on `data_rdata_o` / `data_rvalid_o`.
- Data write: at the accepting edge, each lane with `data_be_i[n]`=1 is updated from `data_wdata_i`; other lanes are unchanged. `be`=0 writes nothing.
- A write also produces `data_rvalid_o`=1 in the next cycle. `data_rdata_o` then carries the word's pre-write contents.
- Same-cycle fetch and data write to the same word: the fetch returns the old word (read-before-write).
- Same-cycle data write then read of that word in the next accepted request: the read returns the new word.
- rdata holds its last value while rvalid=0.
- `mem` is not cleared by reset. Contents persist across reset so a preloaded program survives. Unloaded words are X in simulation.

## Timing
- Reset: `instr_rvalid_o`=0, `data_rvalid_o`=0, `instr_rdata_o`=0, `data_rdata_o`=0. `gnt` outputs follow their combinational rule.
- Read latency is exactly 1 cycle from the accepting edge. Back-to-back requests are accepted every cycle: one response per cycle, in order.
- Reset asserted while a response is pending: the pending rvalid is dropped (0 next cycle). A write accepted at the same edge as reset is still committed.
- There is no outstanding-request limit beyond one in flight per port per cycle. req may be withdrawn without gnt.

## Configuration
- `SIM_MEM_STALL_EN`
  - Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) advances every clock.
  - `instr_gnt_o` = `instr_req_i` & lfsr[0]; `data_gnt_o` = `data_req_i` & lfsr[1]. This gives deterministic backpressure.
  - Latency after acceptance is unchanged.
- Not defined: gnt = req on both ports, and no LFSR exists.

## Test plan
- Preload `mem[0]`=32'h0000_0013, `mem[1]`=32'h0010_0093. Fetch 0x0 then 0x4 on consecutive cycles -> rvalid on the two following cycles with those words, gnt high both cycles.
- Write 32'hDEAD_BEEF, be=4'hF to 0x100, then read 0x100 -> `data_rdata_o`=32'hDEAD_BEEF. The write's own rvalid response carries the prior contents.
- Start with word 0x100 = 32'hDEAD_BEEF. Write 32'h0000_0041, be=4'b0001 to 0x100, then read -> 32'hDEAD_BE41. Then write 32'h1234_0000, be=4'b1100 -> read returns 32'h1234_BE41.
- Same cycle: fetch 0x200 (old 32'h1111_1111) and data write 32'h2222_2222 to 0x200 -> fetch returns 32'h1111_1111, and a later fetch returns 32'h2222_2222.
- Access address DEPTH*4+8 -> aliases `mem[2]`. Assert reset with a read pending -> rvalid 0 next cycle and rdata 0.
- With `SIM_MEM_STALL_EN` defined, hold `data_req_i`=1 for 16 cycles after reset -> gnt pattern matches the LFSR bit-1 sequence from seed 8'hA5. Every gnt is followed by exactly one rvalid.
